// File: rtl/pif_regbank_pkg.sv
// Shared address map, readback tags and sub-address layout helpers for pif_regbank.
package pif_regbank_pkg;

    localparam int unsigned W_SCRATCH_BASE = 1;
    localparam int unsigned W_CTRL_BASE    = 9;
    localparam int unsigned W_LOCK         = 13;
    localparam int unsigned R_ID           = 0;

    localparam logic [7:0] UNLOCK_KEY      = 8'hA5;
    localparam logic [1:0] LED_ALTERNATING = 2'b10;

    localparam logic [1:0] TAG_SCRATCH = 2'b01;
    localparam logic [3:0] TAG_CTRL    = 4'h5;
    localparam logic [3:0] TAG_LETTER  = 4'h6;

    // Stage-1 readback payload: address hit plus candidate byte.
    typedef struct packed {
        logic       hit;
        logic [7:0] data;
    } rd_stage_t;

    function automatic int unsigned scratch_sub(input int unsigned i);
        return 1 + i;
    endfunction

    function automatic int unsigned ctrl_sub(input int unsigned num_scratch, input int unsigned j);
        return 1 + num_scratch + j;
    endfunction

    function automatic int unsigned status_sub(input int unsigned num_scratch, input int unsigned num_ctrl);
        return 1 + num_scratch + num_ctrl;
    endfunction

    function automatic int unsigned wrcnt_sub(input int unsigned num_scratch, input int unsigned num_ctrl);
        return status_sub(num_scratch, num_ctrl) + 1;
    endfunction

endpackage

// File: rtl/pif_rd_pipe.sv
// Fixed-depth 8-bit delay line for the tail of the readback pipeline.
module pif_rd_pipe #(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    logic [7:0] stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= 8'h00;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/pif_regbank.sv
// PIF scratch/lockable-control register bank with fixed-latency XO readback.
// Optional accepted-write counter enabled by defining PIF_REGBANK_WRCNT_EN.
module pif_regbank
    import pif_regbank_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned SUBA_W      = 4,
    parameter int unsigned NUM_SCRATCH = 4,
    parameter int unsigned NUM_CTRL    = 2,
    parameter int unsigned CTRL_W      = 2,
    parameter int unsigned RD_LAT      = 4,
    parameter logic [7:0]  ID_VAL      = 8'h41
) (
    input  logic                       xclk,
    input  logic                       sys_rst,
    input  logic                       xi_pwr,
    input  logic [ADDR_W-1:0]          xi_prwa,
    input  logic                       xi_prdfinished,
    input  logic [SUBA_W-1:0]          xi_prdsuba,
    input  logic [DATA_W-1:0]          xi_pd,
    output logic [7:0]                 xo,
    output logic [NUM_CTRL*CTRL_W-1:0] ctrl_out,
    output logic                       wr_err
);

    localparam int unsigned CTRL_BUS_W = NUM_CTRL * CTRL_W;

    logic [DATA_W-1:0]      scratch [NUM_SCRATCH];
    logic [CTRL_W-1:0]      ctrl    [NUM_CTRL];
    logic                   lock;
    logic [7:0]             rd_cnt;

    logic [NUM_SCRATCH-1:0] scratch_we;
    logic [NUM_CTRL-1:0]    ctrl_hit;
    logic                   lock_we;
    logic                   ctrl_reject;
    logic                   wr_accept;
    logic [CTRL_BUS_W-1:0]  ctrl_flat;

    logic [7:0]             rd_cand;
    rd_stage_t              stage1;
    logic [7:0]             stage2;
    logic                   unused_scratch_hi;

`ifdef PIF_REGBANK_WRCNT_EN
    logic [7:0]             wr_cnt;
`endif

    // Write address decode; only one target can match a given strobe.
    always_comb begin
        scratch_we = '0;
        ctrl_hit   = '0;
        lock_we    = 1'b0;
        if (xi_pwr) begin
            for (int i = 0; i < NUM_SCRATCH; i++)
                scratch_we[i] = (xi_prwa == ADDR_W'(W_SCRATCH_BASE + i));
            for (int j = 0; j < NUM_CTRL; j++)
                ctrl_hit[j] = (xi_prwa == ADDR_W'(W_CTRL_BASE + j));
            lock_we = (xi_prwa == ADDR_W'(W_LOCK));
        end
    end

    assign ctrl_reject = (|ctrl_hit) && lock;
    assign wr_accept   = (|scratch_we) || lock_we || ((|ctrl_hit) && !lock);

    always_comb begin
        ctrl_flat = '0;
        for (int j = 0; j < NUM_CTRL; j++) ctrl_flat[j*CTRL_W +: CTRL_W] = ctrl[j];
    end

    // Upper scratch bits are write-only; they never appear in readback.
    always_comb begin
        unused_scratch_hi = 1'b0;
        for (int i = 0; i < NUM_SCRATCH; i++)
            unused_scratch_hi = unused_scratch_hi ^ (^scratch[i][DATA_W-1:6]);
    end

    always_ff @(posedge xclk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= DATA_W'(8'h15 + i);
            for (int j = 0; j < NUM_CTRL; j++)
                ctrl[j] <= (j == 0) ? CTRL_W'(LED_ALTERNATING) : '0;
            lock     <= 1'b1;
            rd_cnt   <= 8'h00;
            wr_err   <= 1'b0;
            ctrl_out <= '0;
        end else begin
            for (int i = 0; i < NUM_SCRATCH; i++)
                if (scratch_we[i]) scratch[i] <= xi_pd;
            for (int j = 0; j < NUM_CTRL; j++)
                if (ctrl_hit[j] && !lock) ctrl[j] <= xi_pd[CTRL_W-1:0];
            if (lock_we) lock <= (xi_pd != DATA_W'(UNLOCK_KEY));
            if (xi_prdfinished && (rd_cnt != 8'hFF)) rd_cnt <= rd_cnt + 8'd1;
            wr_err   <= ctrl_reject;
            ctrl_out <= ctrl_flat;
        end
    end

`ifdef PIF_REGBANK_WRCNT_EN
    always_ff @(posedge xclk or posedge sys_rst) begin
        if (sys_rst)        wr_cnt <= 8'h00;
        else if (wr_accept) wr_cnt <= wr_cnt + 8'd1;
    end
`else
    logic unused_wr_accept;
    assign unused_wr_accept = wr_accept;
`endif

    // Sub-address readback map; later matches override the letter default.
    always_comb begin
        rd_cand = {TAG_LETTER, 4'(xi_prdsuba)};
        if (xi_prdsuba == '0) rd_cand = ID_VAL;
        for (int i = 0; i < NUM_SCRATCH; i++)
            if (xi_prdsuba == SUBA_W'(scratch_sub(i)))
                rd_cand = {TAG_SCRATCH, scratch[i][5:0]};
        for (int j = 0; j < NUM_CTRL; j++)
            if (xi_prdsuba == SUBA_W'(ctrl_sub(NUM_SCRATCH, j)))
                rd_cand = {TAG_CTRL, 4'(ctrl[j])};
        if (xi_prdsuba == SUBA_W'(status_sub(NUM_SCRATCH, NUM_CTRL)))
            rd_cand = {lock, 3'b000, rd_cnt[3:0]};
`ifdef PIF_REGBANK_WRCNT_EN
        if (xi_prdsuba == SUBA_W'(wrcnt_sub(NUM_SCRATCH, NUM_CTRL)))
            rd_cand = wr_cnt;
`endif
    end

    // Stages 1 and 2: capture candidate, then gate on the ID address.
    always_ff @(posedge xclk or posedge sys_rst) begin
        if (sys_rst) begin
            stage1 <= '0;
            stage2 <= 8'h00;
        end else begin
            stage1.hit  <= (xi_prwa == ADDR_W'(R_ID));
            stage1.data <= rd_cand;
            stage2      <= stage1.hit ? stage1.data : 8'h00;
        end
    end

    pif_rd_pipe #(
        .DEPTH (RD_LAT - 2)
    ) u_rd_pipe (
        .clk  (xclk),
        .rst  (sys_rst),
        .din  (stage2),
        .dout (xo)
    );

endmodule

// File: tb/tb_pif_regbank.sv
// Scoreboard bench for pif_regbank at read latencies 4, 3 and 8 driven in lockstep.
`timescale 1ns/1ps
module tb_pif_regbank;
    import pif_regbank_pkg::*;

    localparam int NS   = 4;
    localparam int NC   = 2;
    localparam int SCR0 = int'(W_SCRATCH_BASE);
    localparam int CTL0 = int'(W_CTRL_BASE);
    localparam int LCK  = int'(W_LOCK);
    localparam logic [3:0] A_RID  = 4'(R_ID);
    localparam logic [3:0] A_SCR  = 4'(W_SCRATCH_BASE);
    localparam logic [3:0] A_CTRL = 4'(W_CTRL_BASE);
    localparam logic [3:0] A_LOCK = 4'(W_LOCK);
    localparam logic [3:0] S_STAT = 4'(NS + NC + 1);
    localparam logic [3:0] S_WCNT = 4'(NS + NC + 2);

    logic       xclk = 1'b0;
    logic       sys_rst;
    logic       xi_pwr;
    logic [3:0] xi_prwa;
    logic       xi_prdfinished;
    logic [3:0] xi_prdsuba;
    logic [7:0] xi_pd;

    logic [7:0] xo4, xo3, xo8;
    logic [3:0] co4, co3, co8;
    logic       we4, we3, we8;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] m_scratch [NS];
    logic [1:0] m_ctrl    [NC];
    logic       m_lock;
    logic [7:0] m_rdcnt;
    logic [7:0] m_wrcnt;
    logic [7:0] q4 [$];
    logic [7:0] q3 [$];
    logic [7:0] q8 [$];

    always #5 xclk = ~xclk;

    pif_regbank #(.RD_LAT(4)) u_dut (
        .xclk(xclk), .sys_rst(sys_rst), .xi_pwr(xi_pwr), .xi_prwa(xi_prwa),
        .xi_prdfinished(xi_prdfinished), .xi_prdsuba(xi_prdsuba), .xi_pd(xi_pd),
        .xo(xo4), .ctrl_out(co4), .wr_err(we4));

    pif_regbank #(.RD_LAT(3)) u_dut3 (
        .xclk(xclk), .sys_rst(sys_rst), .xi_pwr(xi_pwr), .xi_prwa(xi_prwa),
        .xi_prdfinished(xi_prdfinished), .xi_prdsuba(xi_prdsuba), .xi_pd(xi_pd),
        .xo(xo3), .ctrl_out(co3), .wr_err(we3));

    pif_regbank #(.RD_LAT(8)) u_dut8 (
        .xclk(xclk), .sys_rst(sys_rst), .xi_pwr(xi_pwr), .xi_prwa(xi_prwa),
        .xi_prdfinished(xi_prdfinished), .xi_prdsuba(xi_prdsuba), .xi_pd(xi_pd),
        .xo(xo8), .ctrl_out(co8), .wr_err(we8));

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_rd(input logic [3:0] a, input logic [3:0] s);
        int si;
        si = int'(s);
        if (a != A_RID) return 8'h00;
        if (si == 0) return 8'h41;
        if (si <= NS) return {2'b01, m_scratch[si-1][5:0]};
        if (si <= NS + NC) return {6'b0101_00, m_ctrl[si-NS-1]};
        if (si == NS + NC + 1) return {m_lock, 3'b000, m_rdcnt[3:0]};
`ifdef PIF_REGBANK_WRCNT_EN
        if (si == NS + NC + 2) return m_wrcnt;
`endif
        return {4'h6, s};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) m_scratch[i] = 8'(8'h15 + i);
        m_ctrl[0] = 2'b10;
        for (int j = 1; j < NC; j++) m_ctrl[j] = 2'b00;
        m_lock  = 1'b1;
        m_rdcnt = 8'h00;
        m_wrcnt = 8'h00;
    endtask

    // Release reset just after an edge; pipelines hold zeros for LAT-1 more cycles.
    task automatic release_reset();
        sys_rst = 1'b0;
        model_reset();
        q4.delete(); q3.delete(); q8.delete();
        for (int i = 0; i < 3; i++) q4.push_back(8'h00);
        for (int i = 0; i < 2; i++) q3.push_back(8'h00);
        for (int i = 0; i < 7; i++) q8.push_back(8'h00);
    endtask

    task automatic cyc(input logic pwr, input logic [3:0] a, input logic [7:0] d,
                       input logic fin, input logic [3:0] s);
        logic [7:0] e;
        logic [3:0] exp_ctrl;
        logic       exp_err;
        logic       acc;
        int         ai;
        xi_pwr = pwr; xi_prwa = a; xi_pd = d; xi_prdfinished = fin; xi_prdsuba = s;
        e = exp_rd(a, s);
        q4.push_back(e); q3.push_back(e); q8.push_back(e);
        exp_ctrl = {m_ctrl[1], m_ctrl[0]};
        exp_err  = 1'b0;
        acc      = 1'b0;
        ai       = int'(a);
        if (pwr) begin
            if (ai >= SCR0 && ai < SCR0 + NS) begin
                m_scratch[ai-SCR0] = d; acc = 1'b1;
            end else if (ai >= CTL0 && ai < CTL0 + NC) begin
                if (m_lock) exp_err = 1'b1;
                else begin m_ctrl[ai-CTL0] = d[1:0]; acc = 1'b1; end
            end else if (ai == LCK) begin
                m_lock = (d != 8'hA5); acc = 1'b1;
            end
        end
        if (acc) m_wrcnt = m_wrcnt + 8'd1;
        if (fin && m_rdcnt != 8'hFF) m_rdcnt = m_rdcnt + 8'd1;
        @(posedge xclk); #1;
        check("ctrl_out4", 8'(co4), 8'(exp_ctrl));
        check("ctrl_out3", 8'(co3), 8'(exp_ctrl));
        check("ctrl_out8", 8'(co8), 8'(exp_ctrl));
        check("wr_err4", 8'(we4), 8'(exp_err));
        check("wr_err8", 8'(we8), 8'(exp_err));
        if (q4.size() >= 4) check("xo_lat4", xo4, q4.pop_front());
        if (q3.size() >= 3) check("xo_lat3", xo3, q3.pop_front());
        if (q8.size() >= 8) check("xo_lat8", xo8, q8.pop_front());
    endtask

    task automatic idle_rd(input int n, input logic [3:0] s);
        for (int i = 0; i < n; i++) cyc(1'b0, A_RID, 8'h00, 1'b0, s);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_xo4"}, xo4, 8'h00);
        check({tag, "_xo3"}, xo3, 8'h00);
        check({tag, "_xo8"}, xo8, 8'h00);
        check({tag, "_ctrl"}, 8'(co4), 8'h00);
        check({tag, "_err"}, 8'(we4), 8'h00);
    endtask

    initial begin
        logic [3:0] ra;
        logic [7:0] rd;
        sys_rst = 1'b1;
        xi_pwr = 1'b0; xi_prwa = 4'h0; xi_pd = 8'h00; xi_prdfinished = 1'b0; xi_prdsuba = 4'h0;
        repeat (3) @(posedge xclk);
        #1;
        check_reset_outputs("reset");
        release_reset();

        // ID byte and reset scratch value
        idle_rd(10, 4'd0);
        idle_rd(10, 4'd1);

        // scratch write, readback, and gating by non-ID address
        cyc(1'b1, A_SCR + 4'd2, 8'h3C, 1'b0, 4'd3);
        idle_rd(10, 4'd3);
        for (int i = 0; i < 10; i++) cyc(1'b0, 4'h5, 8'h00, 1'b0, 4'd3);

        // locked ctrl write rejected, then unlock and retry
        cyc(1'b1, A_CTRL, 8'h03, 1'b0, 4'd5);
        idle_rd(4, 4'd5);
        cyc(1'b1, A_LOCK, 8'hA5, 1'b0, 4'd7);
        cyc(1'b1, A_CTRL, 8'h03, 1'b0, 4'd5);
        idle_rd(10, 4'd5);
        cyc(1'b1, A_CTRL + 4'd1, 8'hFE, 1'b0, 4'd6);
        idle_rd(10, 4'd6);

        // rd_cnt saturation and lock bit in status
        for (int i = 0; i < 300; i++) cyc(1'b0, A_RID, 8'h00, 1'b1, S_STAT);
        idle_rd(10, S_STAT);
        cyc(1'b1, A_LOCK, 8'h00, 1'b0, S_STAT);
        idle_rd(10, S_STAT);

        // full sub-address sweep
        for (int s = 0; s < 16; s++) begin
            cyc(1'b0, A_RID, 8'h00, 1'b0, 4'(s));
            cyc(1'b0, A_RID, 8'h00, 1'b0, 4'(s));
        end

        // random mixed traffic
        for (int i = 0; i < 600; i++) begin
            ra = ($urandom_range(0, 1) == 1) ? A_RID : 4'($urandom_range(0, 15));
            rd = ($urandom_range(0, 4) == 0) ? 8'hA5 : 8'($urandom);
            cyc(1'($urandom_range(0, 2) == 0), ra, rd, 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)));
        end

        // async reset while a non-zero readback is in flight
        idle_rd(10, 4'd1);
        #1 sys_rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge xclk);
        @(posedge xclk);
        #1;
        check_reset_outputs("midrst_hold");
        release_reset();
        for (int s = 0; s < 16; s++) cyc(1'b0, A_RID, 8'h00, 1'b0, 4'(s));
        idle_rd(10, 4'd15);

`ifdef PIF_REGBANK_WRCNT_EN
        for (int i = 0; i < 257; i++) cyc(1'b1, A_SCR, 8'($urandom), 1'b0, S_WCNT);
        idle_rd(10, S_WCNT);
`endif

        idle_rd(10, 4'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
